// File: rtl/trng_uart_tx.sv
// TRNG sample FIFO feeding an 8N1 UART transmitter with RTS gating.
// Define TRNG_UART_HEX_EN to send each byte as two ASCII hex characters with CR LF every LINE_BYTES bytes.
module trng_uart_tx #(
  parameter int CYCLES_PER_BIT = 5208,
  parameter int FIFO_DEPTH     = 4,
  parameter int LINE_BYTES     = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] i_dat,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_rts_n,
  output logic       o_sout,
  output logic       o_busy
);

`ifdef TRNG_UART_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  localparam int TW = $clog2(CYCLES_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LINE_BYTES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
  localparam logic [LW-1:0] L_LAST = LW'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          sout_q, sout_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          avail_q, avail_d;
  logic          rts_s1_q, rts_s1_d;
  logic          rts_s2_q, rts_s2_d;
  logic          hex_lo_vld_q, hex_lo_vld_d;
  logic [7:0]    hex_lo_q, hex_lo_d;
  logic          cr_q, cr_d;
  logic          lf_q, lf_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;

  logic       push;
  logic       pop;
  logic       start;
  logic       char_vld;
  logic [7:0] next_char;

  logic [7:0] mem [FIFO_DEPTH];
  logic [7:0] rd_data_q;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Storage has no reset; avail_q lags the count by one cycle so rd_data_q is
  // always refreshed from the head entry before it is used.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_q] <= i_dat;
    end
    rd_data_q <= mem[rd_ptr_q];
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    sout_d       = sout_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    hex_lo_vld_d = hex_lo_vld_q;
    hex_lo_d     = hex_lo_q;
    cr_d         = cr_q;
    lf_d         = lf_q;
    line_cnt_d   = line_cnt_q;
    avail_d      = (cnt_q != '0);
    rts_s1_d     = i_rts_n;
    rts_s2_d     = rts_s1_q;
    push         = i_valid & ready_q;
    pop          = 1'b0;
    start        = 1'b0;
    char_vld     = 1'b1;
    next_char    = 8'h00;

    if (hex_lo_vld_q) begin
      next_char = hex_lo_q;
    end else if (cr_q) begin
      next_char = 8'h0D;
    end else if (lf_q) begin
      next_char = 8'h0A;
    end else if (avail_q) begin
      next_char = HEX_EN ? hex_char(rd_data_q[7:4]) : rd_data_q;
    end else begin
      char_vld = 1'b0;
    end

    case (state_q)
      IDLE: begin
        start = char_vld & ~rts_s2_q;
      end
      START: begin
        if (timer_q == T_LAST) begin
          state_d = DATA;
          timer_d = '0;
          bit_d   = 3'd0;
          sout_d  = shift_q[0];
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            sout_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            sout_d  = shift_q[1];
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (timer_q == T_LAST) begin
          state_d = IDLE;
          start   = char_vld & ~rts_s2_q;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = START;
      timer_d = '0;
      sout_d  = 1'b0;
      shift_d = next_char;
      if (hex_lo_vld_q) begin
        hex_lo_vld_d = 1'b0;
      end else if (cr_q) begin
        cr_d = 1'b0;
        lf_d = 1'b1;
      end else if (lf_q) begin
        lf_d = 1'b0;
      end else begin
        pop = 1'b1;
        if (HEX_EN) begin
          // Line break is queued now; the low nibble still outranks it.
          hex_lo_vld_d = 1'b1;
          hex_lo_d     = hex_char(rd_data_q[3:0]);
          if (line_cnt_q == L_LAST) begin
            line_cnt_d = '0;
            cr_d       = 1'b1;
          end else begin
            line_cnt_d = line_cnt_q + LW'(1);
          end
        end
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    ready_d = (cnt_d != C_FULL);
    busy_d  = (state_d != IDLE) || (cnt_d != '0) || hex_lo_vld_d || cr_d || lf_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      sout_q       <= 1'b1;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      avail_q      <= 1'b0;
      rts_s1_q     <= 1'b1;
      rts_s2_q     <= 1'b1;
      hex_lo_vld_q <= 1'b0;
      hex_lo_q     <= 8'h00;
      cr_q         <= 1'b0;
      lf_q         <= 1'b0;
      line_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      sout_q       <= sout_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      avail_q      <= avail_d;
      rts_s1_q     <= rts_s1_d;
      rts_s2_q     <= rts_s2_d;
      hex_lo_vld_q <= hex_lo_vld_d;
      hex_lo_q     <= hex_lo_d;
      cr_q         <= cr_d;
      lf_q         <= lf_d;
      line_cnt_q   <= line_cnt_d;
    end
  end

  assign o_sout  = sout_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_trng_uart_tx.sv
// Directed bench for trng_uart_tx: a UART receiver model pops expected characters from a scoreboard.
// Build with TRNG_UART_HEX_EN defined to exercise the hex/CRLF path.
module tb_trng_uart_tx;
  localparam int CPB = 4;
  localparam int LB  = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] i_dat = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_rts_n = 1'b1;
  logic       o_ready;
  logic       o_sout;
  logic       o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int line_cnt = 0;
  logic [7:0] sb[$];
  int starts[$];

  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  int         mon_k = 0;
  logic [7:0] mon_byte = 8'h00;
  logic [8:0] mon_exp = 9'h000;

  trng_uart_tx #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(4), .LINE_BYTES(LB)) dut (
    .CLK(CLK), .RESET(RESET), .i_dat(i_dat), .i_valid(i_valid), .o_ready(o_ready),
    .i_rts_n(i_rts_n), .o_sout(o_sout), .o_busy(o_busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  task automatic expect_byte(input logic [7:0] b);
`ifdef TRNG_UART_HEX_EN
    sb.push_back(hexc(b[7:4]));
    sb.push_back(hexc(b[3:0]));
    line_cnt++;
    if (line_cnt == LB) begin
      line_cnt = 0;
      sb.push_back(8'h0D);
      sb.push_back(8'h0A);
    end
`else
    sb.push_back(b);
`endif
  endtask

  // Receiver: samples mid-bit on the falling clock edge; one line per frame.
  always @(negedge CLK) begin
    if (RESET) begin
      mon_active = 1'b0;
      mon_cnt    = 0;
    end else begin
      if (!mon_active && o_sout === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        starts.push_back(cyc);
      end
      if (mon_active) begin
        if (mon_cnt % CPB == CPB / 2) begin
          mon_k = mon_cnt / CPB;
          if (mon_k == 0) begin
            chk("start_bit", 32'(o_sout), 0);
          end else if (mon_k <= 8) begin
            mon_byte[mon_k-1] = o_sout;
          end else begin
            chk("stop_bit", 32'(o_sout), 1);
            mon_exp = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h1FF;
            chk("frame_data", 32'(mon_byte), 32'(mon_exp));
            $display("frame @%0d: got %02h expected %03h", starts[$], mon_byte, mon_exp);
          end
        end
        mon_cnt++;
        if (mon_cnt == 10 * CPB) mon_active = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET   = 1'b1;
    i_valid = 1'b0;
    step(2);
    chk("rst_sout", 32'(o_sout), 1);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_busy", 32'(o_busy), 0);
    RESET = 1'b0;
    sb.delete();
    starts.delete();
    line_cnt = 0;
  endtask

  task automatic push(input logic [7:0] b);
    chk("push_ready", 32'(o_ready), 1);
    i_dat   = b;
    i_valid = 1'b1;
    step(1);
    i_valid = 1'b0;
    expect_byte(b);
  endtask

  task automatic wait_fall(output int f);
    int t = 0;
    while (o_sout !== 1'b0 && t < 200) begin
      step(1);
      t++;
    end
    chk("fall_in_time", 32'(t < 200), 1);
    f = cyc;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((sb.size() != 0 || o_busy !== 1'b0) && t < 3000) begin
      step(1);
      t++;
    end
    chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
    chk({tag, "_idle"}, 32'(o_busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    int t0;
    int lows;
    logic [9:0] fr;

`ifndef TRNG_UART_HEX_EN
    // Single byte: exact waveform and latency.
    i_rts_n = 1'b0;
    do_reset();
    step(4);
    push(8'hA5);
    chk("t1_lat_edge0", 32'(o_sout), 1);
    step(1);
    chk("t1_lat_edge1", 32'(o_sout), 1);
    step(1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      chk("t1_bit", 32'(o_sout), 32'(fr[k/CPB]));
      if (k == 20) chk("t1_busy_mid", 32'(o_busy), 1);
      step(1);
    end
    chk("t1_busy_after", 32'(o_busy), 0);
    chk("t1_sb", 32'(sb.size()), 0);

    // FIFO fill with RTS deasserted, then release.
    i_rts_n = 1'b1;
    do_reset();
    step(3);
    for (int i = 0; i < 5; i++) begin
      chk("t2_ready", 32'(o_ready), 32'(i < 4));
      i_dat   = 8'h11 * 8'(i + 1);
      i_valid = 1'b1;
      step(1);
      if (i < 4) expect_byte(i_dat);
    end
    i_valid = 1'b0;
    chk("t2_full", 32'(o_ready), 0);
    step(20);
    chk("t2_no_frame_sout", 32'(o_sout), 1);
    chk("t2_no_frame_cnt", 32'(starts.size()), 0);
    i_rts_n = 1'b0;
    step(2);
    chk("t2_sync_sout", 32'(o_sout), 1);
    chk("t2_sync_ready", 32'(o_ready), 0);
    step(1);
    chk("t2_start", 32'(o_sout), 0);
    chk("t2_ready_back", 32'(o_ready), 1);
    drain("t2");
    chk("t2_frames", 32'(starts.size()), 4);
    for (int i = 0; i + 1 < starts.size(); i++) chk("t2_gap", 32'(starts[i+1] - starts[i]), 10 * CPB);

    // RTS raised mid-frame: current frame completes, next one waits.
    i_rts_n = 1'b0;
    do_reset();
    step(3);
    push(8'h96);
    push(8'h3A);
    wait_fall(f);
    step(17);
    i_rts_n = 1'b1;
    step(43);
    chk("t4_held_sout", 32'(o_sout), 1);
    chk("t4_one_frame", 32'(starts.size()), 1);
    chk("t4_pending", 32'(sb.size()), 1);
    i_rts_n = 1'b0;
    step(2);
    chk("t4_sync_sout", 32'(o_sout), 1);
    step(1);
    chk("t4_resume", 32'(o_sout), 0);
    drain("t4");
`else
    // Hex rendering with a line break after LB bytes.
    i_rts_n = 1'b0;
    do_reset();
    step(3);
    push(8'h3C);
    push(8'h0F);
    chk("t3_queued", 32'(sb.size()), 6);
    wait_fall(f);
    step(10 * CPB * 6 - 1);
    chk("t3_busy_last", 32'(o_busy), 1);
    step(1);
    chk("t3_busy_done", 32'(o_busy), 0);
    chk("t3_sb", 32'(sb.size()), 0);
    chk("t3_frames", 32'(starts.size()), 6);

    // Push offered to a full FIFO on the pop edge is refused, then retried.
    i_rts_n = 1'b1;
    do_reset();
    step(3);
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    chk("t6_full", 32'(o_ready), 0);
    i_dat   = 8'hFF;
    i_valid = 1'b1;
    expect_byte(8'hFF);
    i_rts_n = 1'b0;
    step(2);
    chk("t6_ready_pre", 32'(o_ready), 0);
    chk("t6_sout_pre", 32'(o_sout), 1);
    step(1);
    chk("t6_pop_start", 32'(o_sout), 0);
    chk("t6_ready_pop", 32'(o_ready), 1);
    step(1);
    chk("t6_ready_refill", 32'(o_ready), 0);
    i_valid = 1'b0;
    drain("t6");
`endif

    // Reset mid-DATA with bytes still queued.
    i_rts_n = 1'b0;
    do_reset();
    step(3);
    for (int i = 0; i < 4; i++) push(8'h01 + 8'(i));
    wait_fall(f);
    step(12);
    RESET = 1'b1;
    step(1);
    chk("t5_sout", 32'(o_sout), 1);
    chk("t5_ready", 32'(o_ready), 1);
    chk("t5_busy", 32'(o_busy), 0);
    RESET = 1'b0;
    sb.delete();
    line_cnt = 0;
    t0   = starts.size();
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (o_sout !== 1'b1) lows++;
    end
    chk("t5_line_idle", 32'(lows), 0);
    chk("t5_no_frames", 32'(starts.size() - t0), 0);
    chk("t5_busy_after", 32'(o_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
